// File: rtl/partition_sweep_ctrl.sv
// Exhaustive input sweep for an exact/approximate partition pair: drives every pi pattern,
// samples both output vectors after a settle delay, streams each response and accumulates error stats.
`timescale 1ns/1ps
module partition_sweep_ctrl #(
   parameter int NUM_PI     = 8,
   parameter int NUM_PO     = 5,
   parameter int SETTLE_CYC = 1,
   localparam int HDW       = $clog2(NUM_PO + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [NUM_PI-1:0]     pi,
   input  logic [NUM_PO-1:0]     po_exact,
   input  logic [NUM_PO-1:0]     po_approx,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [NUM_PI-1:0]     resp_pi,
   output logic [NUM_PO-1:0]     resp_exact,
   output logic [NUM_PO-1:0]     resp_approx,
   output logic                  busy,
   output logic                  done,
   output logic [NUM_PI:0]       err_count,
   output logic [NUM_PI+HDW-1:0] hd_sum,
   output logic [HDW-1:0]        hd_max
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SAMPLE = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [NUM_PI-1:0] LAST_PI    = {NUM_PI{1'b1}};
   localparam logic [3:0]        SETTLE_VAL = 4'(SETTLE_CYC);

   state_t            state;
   state_t            state_next;
   logic [3:0]        cnt;
   logic [NUM_PO-1:0] diff;
   logic [HDW-1:0]    hd;
   logic              handshake;

   assign handshake = resp_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Valid/ready: resp_valid is high for the whole of EMIT and resp_* hold until
   // the cycle resp_valid && resp_ready is seen; abort outranks that handshake.
   always_comb begin
      state_next = state;
      resp_valid = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_next = IDLE;
            end else if (cnt == 4'd1) begin
               state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            state_next = abort ? IDLE : EMIT;
         end
         EMIT: begin
            resp_valid = 1'b1;
            if (abort) begin
               state_next = IDLE;
            end else if (resp_ready) begin
               state_next = (pi == LAST_PI) ? DONE : SETTLE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Per-pattern Hamming distance between the two partition outputs.
   always_comb begin
      diff = po_exact ^ po_approx;
      hd   = '0;
      for (int i = 0; i < NUM_PO; i++) begin
         hd = hd + HDW'(diff[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pi          <= '0;
         cnt         <= '0;
         resp_pi     <= '0;
         resp_exact  <= '0;
         resp_approx <= '0;
         err_count   <= '0;
         hd_sum      <= '0;
         hd_max      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pi        <= '0;
                  cnt       <= SETTLE_VAL;
                  err_count <= '0;
                  hd_sum    <= '0;
                  hd_max    <= '0;
               end
            end
            SETTLE: begin
               if (!abort) begin
                  cnt <= cnt - 4'd1;
               end
            end
            SAMPLE: begin
               // An abort here leaves the statistics at their partial value.
               if (!abort) begin
                  resp_pi     <= pi;
                  resp_exact  <= po_exact;
                  resp_approx <= po_approx;
                  err_count   <= err_count + (NUM_PI+1)'(hd != '0);
                  hd_sum      <= hd_sum + (NUM_PI+HDW)'(hd);
                  if (hd > hd_max) begin
                     hd_max <= hd;
                  end
               end
            end
            EMIT: begin
               if (!abort && handshake && (pi != LAST_PI)) begin
                  pi  <= pi + NUM_PI'(1);
                  cnt <= SETTLE_VAL;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Directed bench for partition_sweep_ctrl: a behavioural partition pair feeds the sweep,
// every streamed beat is scored against an expected queue and final stats against hand values.
`timescale 1ns/1ps
module tb_partition_sweep_ctrl;

   localparam int NUM_PI = 8;
   localparam int NUM_PO = 5;
   localparam int HDW    = 3;
   localparam int BEAT_W = NUM_PI + 2*NUM_PO;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  abort;
   logic [NUM_PI-1:0]     pi;
   logic [NUM_PO-1:0]     po_exact;
   logic [NUM_PO-1:0]     po_approx;
   logic                  resp_valid;
   logic                  resp_ready = 1'b1;
   logic [NUM_PI-1:0]     resp_pi;
   logic [NUM_PO-1:0]     resp_exact;
   logic [NUM_PO-1:0]     resp_approx;
   logic                  busy;
   logic                  done;
   logic [NUM_PI:0]       err_count;
   logic [NUM_PI+HDW-1:0] hd_sum;
   logic [HDW-1:0]        hd_max;

   int n_checks = 0;
   int n_pass   = 0;
   int mode     = 1;
   bit rand_ready = 1'b0;
   bit mon_en     = 1'b0;
   int done_cnt   = 0;
   logic [BEAT_W-1:0] exp_q[$];

   partition_sweep_ctrl #(.NUM_PI(NUM_PI), .NUM_PO(NUM_PO), .SETTLE_CYC(1)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pi(pi),
      .po_exact(po_exact), .po_approx(po_approx),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pi(resp_pi),
      .resp_exact(resp_exact), .resp_approx(resp_approx),
      .busy(busy), .done(done), .err_count(err_count), .hd_sum(hd_sum), .hd_max(hd_max)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- partition pair model ----------------
   function automatic logic [NUM_PO-1:0] f_exact(input logic [NUM_PI-1:0] p);
      return p[4:0] ^ {p[2:0], p[7:6]};
   endfunction

   // mode 1: identity, 2: LSB flipped everywhere, 3: 5'b10110 flipped only at 8'hA5
   function automatic logic [NUM_PO-1:0] f_approx(input logic [NUM_PI-1:0] p, input int m);
      logic [NUM_PO-1:0] e;
      e = f_exact(p);
      case (m)
         2:       return e ^ 5'b00001;
         3:       return (p == 8'hA5) ? (e ^ 5'b10110) : e;
         default: return e;
      endcase
   endfunction

   always_comb begin
      po_exact  = f_exact(pi);
      po_approx = f_approx(pi, mode);
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- drivers ----------------
   always @(posedge clk) begin
      #1;
      resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic run_sweep(input int m, input bit rnd, input bit extra,
                            input int e_err, input int e_sum, input int e_max);
      int cyc;
      mode       = m;
      rand_ready = rnd;
      exp_q.delete();
      for (int p = 0; p < 256; p++) begin
         exp_q.push_back({8'(p), f_exact(8'(p)), f_approx(8'(p), m)});
      end
      mon_en = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 3000) begin
         start = extra && (cyc == 100);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 1);
      if (!rnd) check("done_latency", cyc, 769);
      check("err_count", 32'(err_count), e_err);
      check("hd_sum", 32'(hd_sum), e_sum);
      check("hd_max", 32'(hd_max), e_max);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);
      check("beats_left", 32'(exp_q.size()), 0);
      check("stats_hold", 32'(err_count), e_err);
      mon_en = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mon_en && resp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(exp_q.size()), 1);
         end else begin
            check("beat", 32'({resp_pi, resp_exact, resp_approx}), 32'(exp_q[0]));
            if (resp_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int snap;
      bit found;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pi", 32'(pi), 0);
      check("rst_valid", 32'(resp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err_count), 0);
      check("rst_hd_sum", 32'(hd_sum), 0);
      rst = 1'b0;

      // T1..T3: ready tied high
      run_sweep(1, 1'b0, 1'b0, 0, 0, 0);
      run_sweep(2, 1'b0, 1'b0, 256, 256, 1);
      run_sweep(3, 1'b0, 1'b0, 1, 3, 3);
      // T4: ready with 50% duty
      run_sweep(2, 1'b1, 1'b0, 256, 256, 1);

      // T5: abort collides with the handshake of pattern 8'h3F, so 8'h40 is never sampled
      mode = 2; rand_ready = 1'b0;
      exp_q.delete();
      for (int p = 0; p < 64; p++) begin
         exp_q.push_back({8'(p), f_exact(8'(p)), f_approx(8'(p), 2)});
      end
      mon_en = 1'b1;
      snap = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (resp_valid && resp_pi == 8'h3F) found = 1'b1;
      end
      check("t5_reach_3f", 32'(found), 1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check("t5_busy", 32'(busy), 0);
      check("t5_valid", 32'(resp_valid), 0);
      check("t5_err", 32'(err_count), 64);
      check("t5_hd_sum", 32'(hd_sum), 64);
      check("t5_hd_max", 32'(hd_max), 1);
      check("t5_pi", 32'(pi), 32'h3F);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t5_idle_abort", 32'(busy), 0);
      check("t5_err_frozen", 32'(err_count), 64);
      check("t5_no_done", 32'(done_cnt - snap), 0);
      check("t5_beats_left", 32'(exp_q.size()), 0);
      mon_en = 1'b0;

      // T6: reset during SETTLE of pattern 3, then a sweep with a stray start
      mode = 2;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("t6_partial_err", 32'(err_count), 3);
      check("t6_busy", 32'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("t6_pi", 32'(pi), 0);
      check("t6_busy_rst", 32'(busy), 0);
      check("t6_valid", 32'(resp_valid), 0);
      check("t6_resp", 32'({resp_pi, resp_exact, resp_approx}), 0);
      check("t6_err", 32'(err_count), 0);
      check("t6_hd_sum", 32'(hd_sum), 0);
      check("t6_hd_max", 32'(hd_max), 0);
      check("t6_done", 32'(done), 0);
      run_sweep(2, 1'b0, 1'b1, 256, 256, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
